// File: rtl/ham_encoder_tx.sv
// Purpose: Hamming(7,4) encoder feeding a codeword FIFO and a bit-serial framer (SOF/EOF marked).
// Latency: nibble accepted on edge k -> first bit (tx_sof) presented after edge k+1 from an idle system.
// Backpressure: din_ready drops when the FIFO is full; tx_ready=0 freezes all tx_* outputs.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   din/din_valid/din_ready   4-bit nibble in (din[0]=d1 .. din[3]=d4), valid/ready handshake
//   tx_bit/tx_valid/tx_ready  serial codeword bit out, valid/ready handshake
//   tx_sof, tx_eof       first / last bit of the codeword currently presented
//   fifo_level           codewords queued (the one in the shifter is not counted)
//   inj_en, inj_pos      only with HAM_ERR_INJECT_EN: flip codeword position inj_pos (1..7) on accept
//
// Optional feature macro: HAM_ERR_INJECT_EN (adds inj_en/inj_pos error injection ports).
// Codeword layout: code[i-1] is position i; positions 1..7 = p1 p2 d1 p4 d2 d3 d4.

module ham_encoder_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int BIT_ORDER  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          tx_bit,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          tx_sof,
  output logic                          tx_eof,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef HAM_ERR_INJECT_EN
  ,
  input  logic                          inj_en,
  input  logic [2:0]                    inj_pos
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  // ---------------------------------------------------------------------------
  // Encoder (combinational on din)
  // ---------------------------------------------------------------------------
  logic [6:0] enc_code;
  logic [6:0] wr_code;

  always_comb begin
    enc_code    = '0;
    enc_code[0] = din[0] ^ din[1] ^ din[3];  // p1
    enc_code[1] = din[0] ^ din[2] ^ din[3];  // p2
    enc_code[2] = din[0];                    // d1
    enc_code[3] = din[1] ^ din[2] ^ din[3];  // p4
    enc_code[4] = din[1];                    // d2
    enc_code[5] = din[2];                    // d3
    enc_code[6] = din[3];                    // d4
  end

`ifdef HAM_ERR_INJECT_EN
  logic [6:0] inj_mask;

  // inj_pos=0 means "no error"; positions 1..7 map to codeword bits 0..6.
  always_comb begin
    inj_mask = '0;
    if (inj_en && (inj_pos != 3'd0)) begin
      inj_mask = 7'd1 << (inj_pos - 3'd1);
    end
  end

  assign wr_code = enc_code ^ inj_mask;
`else
  assign wr_code = enc_code;
`endif

  // ---------------------------------------------------------------------------
  // Codeword FIFO
  // ---------------------------------------------------------------------------
  logic [6:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full       = (level_q == LW'(FIFO_DEPTH));
  assign empty      = (level_q == '0);
  // No pass-through: a full FIFO refuses input even if the shifter pops this cycle.
  assign din_ready  = !full && !rst;
  assign push       = din_valid && din_ready;
  assign fifo_level = level_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_code;
    end
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------------
  state_t     state_q;
  state_t     state_d;
  logic [6:0] shreg;
  logic [2:0] bit_cnt;
  logic       adv;
  logic [2:0] bit_idx;

  assign bit_idx = (BIT_ORDER == 0) ? bit_cnt : (3'd6 - bit_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    adv      = 1'b0;
    tx_valid = 1'b0;
    tx_bit   = 1'b0;
    tx_sof   = 1'b0;
    tx_eof   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        tx_valid = 1'b1;
        tx_bit   = shreg[bit_idx];
        tx_sof   = (bit_cnt == 3'd0);
        tx_eof   = (bit_cnt == 3'd6);
        if (tx_ready) begin
          if (bit_cnt != 3'd6) begin
            adv = 1'b1;
          end else if (!empty) begin
            // Reload on the last bit so consecutive frames have no gap.
            pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (pop) begin
      shreg   <= mem[rd_ptr];
      bit_cnt <= '0;
    end else if (adv) begin
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_ham_encoder_tx.sv
// Directed bench for ham_encoder_tx: table of nibbles with hand-computed
// codewords, plus latency, back-to-back, backpressure, FIFO-full and
// mid-frame reset sequences.

module tb_ham_encoder_tx;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    din;
  logic          din_valid;
  logic          din_ready;
  logic          tx_bit;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx_sof;
  logic          tx_eof;
  logic [LW-1:0] fifo_level;
`ifdef HAM_ERR_INJECT_EN
  logic          inj_en;
  logic [2:0]    inj_pos;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ham_encoder_tx #(.FIFO_DEPTH(DEPTH), .BIT_ORDER(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .tx_bit     (tx_bit),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_sof     (tx_sof),
    .tx_eof     (tx_eof),
    .fifo_level (fifo_level)
`ifdef HAM_ERR_INJECT_EN
    ,
    .inj_en     (inj_en),
    .inj_pos    (inj_pos)
`endif
  );

  typedef struct {
    logic [3:0] din;
    logic [6:0] code;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Called at a negedge; offers one nibble for the next rising edge.
  task automatic push(input logic [3:0] d, input string name);
    din       = d;
    din_valid = 1'b1;
    check({name, " din_ready"}, 32'(din_ready), 32'd1);
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  // Collects one frame starting at the current negedge. Position n+1 arrives
  // as the n-th accepted bit (BIT_ORDER=0). With toggle set, tx_ready is
  // randomised and outputs must not change while a bit is not consumed.
  task automatic recv_frame(input string name, input logic [6:0] exp, input bit toggle,
                            output int first_wait, output logic [6:0] got);
    int       n;
    int       waited;
    int       bad_mark;
    int       bad_hold;
    bit       held_vld;
    logic [2:0] held;
    got        = '0;
    n          = 0;
    waited     = 0;
    bad_mark   = 0;
    bad_hold   = 0;
    held_vld   = 1'b0;
    held       = '0;
    first_wait = -1;
    while (n < 7 && waited < 200) begin
      if (held_vld && ({tx_valid, tx_bit, tx_sof, tx_eof} !== {1'b1, held})) bad_hold++;
      tx_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      held_vld = 1'b0;
      if (tx_valid) begin
        if (first_wait < 0) first_wait = waited;
        if (tx_ready) begin
          got[n] = tx_bit;
          if (tx_sof !== (n == 0) || tx_eof !== (n == 6)) bad_mark++;
          n++;
        end else begin
          held_vld = 1'b1;
          held     = {tx_bit, tx_sof, tx_eof};
        end
      end
      waited++;
      @(negedge clk);
    end
    tx_ready = 1'b1;
    check({name, " bits received"}, 32'(n), 32'd7);
    check({name, " codeword"}, 32'(got), 32'(exp));
    check({name, " sof/eof marks"}, 32'(bad_mark), 32'd0);
    if (toggle) check({name, " hold while stalled"}, 32'(bad_hold), 32'd0);
  endtask

  function automatic logic [2:0] syndrome(input logic [6:0] c);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < 7; i++) begin
      if (c[i]) s = s ^ 3'(i + 1);
    end
    return s;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int         fw;
    int         stale;
    logic [6:0] got;

    // Hand-computed codewords, bit i = position i+1 (p1 p2 d1 p4 d2 d3 d4).
    vecs[0] = '{din: 4'b1011, code: 7'b1010101};
    vecs[1] = '{din: 4'b0000, code: 7'b0000000};
    vecs[2] = '{din: 4'b1111, code: 7'b1111111};
    vecs[3] = '{din: 4'b0001, code: 7'b0000111};
    vecs[4] = '{din: 4'b0010, code: 7'b0011001};
    vecs[5] = '{din: 4'b0100, code: 7'b0101010};
    vecs[6] = '{din: 4'b1000, code: 7'b1001011};
    vecs[7] = '{din: 4'b0110, code: 7'b0110011};

    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    tx_ready  = 1'b0;
`ifdef HAM_ERR_INJECT_EN
    inj_en    = 1'b0;
    inj_pos   = '0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("reset tx_valid", 32'(tx_valid), 32'd0);
    check("reset tx_bit", 32'(tx_bit), 32'd0);
    check("reset tx_sof", 32'(tx_sof), 32'd0);
    check("reset tx_eof", 32'(tx_eof), 32'd0);
    check("reset fifo_level", 32'(fifo_level), 32'd0);
    check("reset din_ready", 32'(din_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post-reset din_ready", 32'(din_ready), 32'd1);
    @(negedge clk);

    // Single codeword, latency and return to idle
    tx_ready = 1'b1;
    push(4'b1011, "t1 push");
    check("t1 tx_valid after accept edge", 32'(tx_valid), 32'd0);
    check("t1 fifo_level after accept", 32'(fifo_level), 32'd1);
    @(negedge clk);
    check("t1 tx_valid after accept+1", 32'(tx_valid), 32'd1);
    check("t1 tx_sof after accept+1", 32'(tx_sof), 32'd1);
    check("t1 fifo_level after load", 32'(fifo_level), 32'd0);
    recv_frame("t1", 7'b1010101, 1'b0, fw, got);
    check("t1 idle tx_valid", 32'(tx_valid), 32'd0);

    // Back-to-back frames with no gap
    push(4'b0000, "t2 push0");
    push(4'b1111, "t2 push1");
    recv_frame("t2 frame0", 7'b0000000, 1'b0, fw, got);
    recv_frame("t2 frame1", 7'b1111111, 1'b0, fw, got);
    check("t2 frame1 gap", 32'(fw), 32'd0);

    // Table of nibbles, each from an idle system
    foreach (vecs[i]) begin
      push(vecs[i].din, $sformatf("tbl%0d push", i));
      recv_frame($sformatf("tbl%0d", i), vecs[i].code, 1'b0, fw, got);
      check($sformatf("tbl%0d latency", i), 32'(fw), 32'd1);
    end

    // FIFO fill under backpressure
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(vecs[i].din, $sformatf("t3 push%0d", i));
    check("t3 fifo_level full", 32'(fifo_level), 32'd4);
    check("t3 shifter loaded", 32'(tx_valid), 32'd1);
    din       = vecs[5].din;
    din_valid = 1'b1;
    check("t3 6th din_ready", 32'(din_ready), 32'd0);
    @(negedge clk);
    din_valid = 1'b0;
    check("t3 fifo_level after refused", 32'(fifo_level), 32'd4);
    for (int i = 0; i < 5; i++) begin
      recv_frame($sformatf("t3 drain%0d", i), vecs[i].code, 1'b0, fw, got);
    end
    check("t3 drained fifo_level", 32'(fifo_level), 32'd0);
    check("t3 drained tx_valid", 32'(tx_valid), 32'd0);

    // Random tx_ready stalls mid-frame
    push(vecs[6].din, "t4 push0");
    recv_frame("t4 frame0", vecs[6].code, 1'b1, fw, got);
    push(vecs[7].din, "t4 push1");
    recv_frame("t4 frame1", vecs[7].code, 1'b1, fw, got);
    push(vecs[0].din, "t4 push2");
    recv_frame("t4 frame2", vecs[0].code, 1'b1, fw, got);

    // Reset on the third bit of a frame with two codewords queued
    tx_ready = 1'b0;
    push(vecs[3].din, "t5 push0");
    push(vecs[4].din, "t5 push1");
    push(vecs[5].din, "t5 push2");
    check("t5 fifo_level queued", 32'(fifo_level), 32'd2);
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("t5 on bit 3", 32'(tx_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("t5 tx_valid async drop", 32'(tx_valid), 32'd0);
    check("t5 fifo_level cleared", 32'(fifo_level), 32'd0);
    check("t5 din_ready in reset", 32'(din_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5 din_ready after release", 32'(din_ready), 32'd1);
    @(negedge clk);
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      if (tx_valid) stale++;
      @(negedge clk);
    end
    check("t5 stale bits after reset", 32'(stale), 32'd0);
    push(vecs[7].din, "t5 fresh push");
    recv_frame("t5 fresh", vecs[7].code, 1'b0, fw, got);

`ifdef HAM_ERR_INJECT_EN
    // Error injection at position 7, then inj_pos=0 which must inject nothing
    inj_en  = 1'b1;
    inj_pos = 3'd7;
    push(4'b1011, "t6 push");
    inj_en  = 1'b0;
    inj_pos = 3'd0;
    recv_frame("t6 injected", 7'b0010101, 1'b0, fw, got);
    check("t6 syndrome", 32'(syndrome(got)), 32'd7);
    inj_en  = 1'b1;
    inj_pos = 3'd0;
    push(4'b1011, "t6 pos0 push");
    inj_en  = 1'b0;
    recv_frame("t6 pos0", 7'b1010101, 1'b0, fw, got);
    check("t6 pos0 syndrome", 32'(syndrome(got)), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
